// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: control bundle layout,
// ALUOp encodings and the nop control word.
package mips_pipe_pkg;

    localparam int CTRL_W = 10;

    // Control bundle bit positions, MSB to LSB
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_JUMP     = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/sat_event_counter.sv
// Event counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall bubbles, flush squash and global hold.
// Optional bubble/flush statistics counters are built when IDEX_STATS_EN is defined.
module id_ex_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Pipe_stall,
    input  logic              flush,
    input  logic              hold,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [DATA_W-1:0] ID_PC4,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic              ID_Valid,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [DATA_W-1:0] EX_PC4,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [REG_W-1:0]  EX_Rs,
    output logic [REG_W-1:0]  EX_Rt,
    output logic [REG_W-1:0]  EX_Rd,
    output logic              EX_Valid,
    output logic              ID_EX_MemRead,
    output logic [REG_W-1:0]  ID_EX_RegisterRt
`ifdef IDEX_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              valid_q, valid_d;
    logic              kill_slot;

    // Flush and stall both empty the slot; operands still load so EX_Rt tracks ID.
    assign kill_slot = flush | Pipe_stall;

    always_comb begin
        ctrl_d  = ctrl_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        if (!hold) begin
            pc4_d   = ID_PC4;
            rd1_d   = ID_ReadData1;
            rd2_d   = ID_ReadData2;
            imm_d   = ID_Imm;
            rs_d    = ID_Rs;
            rt_d    = ID_Rt;
            rd_d    = ID_Rd;
            valid_d = ID_Valid & ~kill_slot;
            ctrl_d  = valid_d ? ID_Ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= CTRL_NOP;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign EX_Ctrl          = ctrl_q;
    assign EX_PC4           = pc4_q;
    assign EX_ReadData1     = rd1_q;
    assign EX_ReadData2     = rd2_q;
    assign EX_Imm           = imm_q;
    assign EX_Rs            = rs_q;
    assign EX_Rt            = rt_q;
    assign EX_Rd            = rd_q;
    assign EX_Valid         = valid_q;
    assign ID_EX_MemRead    = ctrl_q[CTRL_MEMREAD];
    assign ID_EX_RegisterRt = rt_q;

`ifdef IDEX_STATS_EN
    logic bubble_inc;
    logic flush_inc;

    // A combined flush+stall is accounted as a flush only.
    assign bubble_inc = ~hold & Pipe_stall & ~flush;
    assign flush_inc  = ~hold & flush;

    sat_event_counter #(.CNT_W(32)) u_bubble_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_event_counter #(.CNT_W(32)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the 5-stage 32-bit MIPS pipeline. It captures decoded control and operand fields from ID each cycle. It turns the hazard unit's `Pipe_stall` into a control bubble, and turns a branch `flush` into an invalid slot. It also honours a global `hold` freeze. It is the receiving end of the load-use stall handshake and feeds EX, the forwarding unit and the hazard unit's `ID_EX_MemRead` / `ID_EX_RegisterRt` inputs.

## Interface
Parameters:
- `DATA_W`, 32: datapath width.
- `REG_W`, 5: register-specifier width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Pipe_stall` in 1: load-use bubble request from the hazard unit.
- `flush` in 1: branch-taken squash of the ID slot.
- `hold` in 1: global freeze; the register keeps its contents.
- `ID_Ctrl` in 10: RegWrite, MemtoReg, MemRead, MemWrite, Branch, RegDst, ALUSrc, ALUOp[1:0], Jump, packed MSB to LSB.
- `ID_PC4` in DATA_W: PC+4.
- `ID_ReadData1`, `ID_ReadData2` in DATA_W: register-file read data.
- `ID_Imm` in DATA_W: sign-extended immediate.
- `ID_Rs`, `ID_Rt`, `ID_Rd` in REG_W: register specifiers.
- `ID_Valid` in 1: the ID slot holds a real instruction.
- `EX_Ctrl` out 10: registered control bundle.
- `EX_PC4`, `EX_ReadData1`, `EX_ReadData2`, `EX_Imm` out DATA_W: registered data fields.
- `EX_Rs`, `EX_Rt`, `EX_Rd` out REG_W: registered register specifiers.
- `EX_Valid` out 1: registered valid bit.
- `ID_EX_MemRead` out 1: alias of the `EX_Ctrl` MemRead bit, for the hazard unit.
- `ID_EX_RegisterRt` out REG_W: alias of `EX_Rt`, for the hazard unit.
- `bubble_cnt`, `flush_cnt` out 32: present only with `IDEX_STATS_EN`.

## Operation
Per-edge priority, highest first:
- **`reset`:** every output register and counter is cleared to 0.
- **`hold`:** all registers keep their values. A `Pipe_stall` or `flush` arriving in the same cycle is ignored, because the hazard unit re-asserts it next cycle from the held state.
- **`flush`:**
  - `EX_Ctrl` ← 0, `EX_Valid` ← 0.
  - Data and specifier fields load from ID; their contents are don't-care.
- **`Pipe_stall`:**
  - `EX_Ctrl` ← 0 (nop bubble), `EX_Valid` ← 0.
  - Data and specifiers load from ID, so `EX_Rt` tracks the stalled instruction.
- **Otherwise:** every field loads from ID. `EX_Valid` ← `ID_Valid`, and `EX_Ctrl` ← `ID_Ctrl` when `ID_Valid` = 1, else 0.
- `flush` and `Pipe_stall` together give a single bubble and, when stats are enabled, count once as a flush.
- Invariant: when `EX_Valid` = 0, `EX_Ctrl` = 0. A bubble therefore cannot write the register file or memory.

## Timing
- Latency is 1 cycle, ID to EX. Outputs are purely registered, with no combinational path from input to output.
- Load-use handshake:
  - Cycle N: the hazard unit sees `ID_EX_MemRead` = 1 with an Rt match and asserts `Pipe_stall`.
  - Edge N+1: the bubble lands, so `ID_EX_MemRead` = 0 and the stall deasserts.
  - Cycle N+1: the held IF/ID instruction loads normally.
  - The stall therefore lasts exactly one cycle per load-use pair.
- `hold` asserted for k cycles freezes all outputs for k edges. Release loads the next ID value on the first edge after `hold` falls.
- `reset` asserted mid-stream discards all in-flight state on that edge. The first edge with `reset` = 0 loads normally.

## Configuration
- Macro: `IDEX_STATS_EN`.
- **Defined:**
  - `bubble_cnt` increments on every edge that applies a `Pipe_stall` bubble.
  - `flush_cnt` increments on every edge that applies a `flush`.
  - Neither counter changes under `hold` or `reset`; `reset` clears both.
  - Both saturate at 0xFFFF_FFFF and do not wrap.
- **Undefined:** both ports and their logic are absent. Datapath behaviour is identical in both builds.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the ctrl bundle width (10) and the bit index constants for each control bit;
  - the ALUOp encodings;
  - the `CTRL_NOP` = 0 constant.
- Sub-module `sat_event_counter` (32-bit, inc, sync clear, saturating) is instantiated twice under `IDEX_STATS_EN`.
- Everything else is flat register logic in one module.

## Test plan
- **Reset:** assert `reset` with all inputs 1s → every output is 0 on the next edge; deassert → the next edge loads ID.
- **Normal load:** `ID_Ctrl` = 10'h2A5, `ID_ReadData1` = 0x1234_5678, `ID_Rt` = 5'd9, `ID_Valid` = 1 → one edge later `EX_Ctrl` = 10'h2A5, `EX_ReadData1` = 0x1234_5678, `ID_EX_RegisterRt` = 9, `EX_Valid` = 1.
- **Load-use:**
  - Load lw `$9` into EX (`ID_EX_MemRead` = 1), then drive `Pipe_stall` = 1 for one cycle.
  - Next edge: `EX_Ctrl` = 0, `EX_Valid` = 0.
  - Following edge: the held add loads; with stats enabled, `bubble_cnt` = 1.
- **Hold priority:** `hold` = 1 and `flush` = 1 together for 3 cycles → outputs unchanged, `flush_cnt` unchanged. Release with `flush` = 0 → the ID value loads.
- **Simultaneous flush and stall:** `flush` = 1 and `Pipe_stall` = 1 → `EX_Ctrl` = 0, `EX_Valid` = 0, `flush_cnt` +1, `bubble_cnt` +0.
- **Saturation:** force `bubble_cnt` to 0xFFFF_FFFE, then apply 3 bubbles → reads 0xFFFF_FFFF and stays there.
